// File: rtl/aes128_enc_sequencer.sv
// aes128_enc_sequencer: iterative AES-128 encryption, one round per two cycles over a shared S-box
module aes128_enc_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext,
  output logic [127:0] sbox_in,
  input  logic [127:0] sbox_out
);
  typedef enum logic [1:0] {IDLE, KEXP, RND} state_t;
  state_t       state_q;
  logic [127:0] st_q, rk_q, st_d, rk_d, sr;
  logic [31:0]  w0_d, w1_d, w2_d, w3_d;
  logic [3:0]   rnd_q;
  logic [7:0]   rcon_q;
  logic         last;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  // S-box operand select, round datapath and next round key from the shared S-box result
  always_comb begin
    last = rnd_q == 4'(NR);
    sbox_in = state_q == KEXP ? {rk_q[23:0], rk_q[31:24], 96'h0} : state_q == RND ? st_q : 128'h0;
    sr = shift_rows(sbox_out);
    st_d = (last ? sr : {mix_col(sr[127:96]), mix_col(sr[95:64]), mix_col(sr[63:32]), mix_col(sr[31:0])}) ^ rk_q;
    w0_d = rk_q[127:96] ^ sbox_out[127:96] ^ {rcon_q, 24'h0};
    w1_d = rk_q[95:64] ^ w0_d;
    w2_d = rk_q[63:32] ^ w1_d;
    w3_d = rk_q[31:0] ^ w2_d;
    rk_d = {w0_d, w1_d, w2_d, w3_d};
  end

  // Control FSM alternating key expansion and round, with registered status and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      st_q       <= '0;
      rk_q       <= '0;
      rnd_q      <= '0;
      rcon_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          st_q    <= plaintext ^ key;
          rk_q    <= key;
          rnd_q   <= 4'd1;
          rcon_q  <= 8'h01;
          busy    <= 1'b1;
          state_q <= KEXP;
        end
        KEXP: begin
          rk_q    <= rk_d;
          state_q <= RND;
        end
        RND: begin
          st_q <= st_d;
          if (last) begin
            ciphertext <= st_d;
            done       <= 1'b1;
            busy       <= 1'b0;
            state_q    <= IDLE;
          end else begin
            rnd_q   <= rnd_q + 4'd1;
            rcon_q  <= xtime(rcon_q);
            state_q <= KEXP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_enc_sequencer.sv
// tb_aes128_enc_sequencer: randomized and known-answer checks against a behavioural AES model
module tb_aes128_enc_sequencer;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [127:0] plaintext = '0, key = '0;
  logic         busy, done;
  logic [127:0] ciphertext, sbox_in, sbox_out;
  logic [7:0]   sbox_tab [256];
  int           vecs = 0, errs = 0;
  bit           chk = 1'b0;
  logic         m_busy = 1'b0, m_done = 1'b0;
  int           m_p = 0;
  logic [127:0] m_pt = '0, m_key = '0, m_ct = '0;

  aes128_enc_sequencer #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .plaintext(plaintext), .key(key),
    .busy(busy), .done(done), .ciphertext(ciphertext),
    .sbox_in(sbox_in), .sbox_out(sbox_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0]  y;
    logic [15:0] d;
    y = 8'h01;
    for (int i = 0; i < 254; i++) y = gmul(y, x);
    if (x == 8'h00) y = 8'h00;
    d = {y, y};
    return y ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] state_in(input logic [127:0] pt, input logic [127:0] k, input int r);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] v, rk;
    v = pt ^ k;
    for (int n = 1; n < r; n++) begin
      for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
      for (int i = 0; i < 16; i++) u[i] = sbox_tab[s[4*((i/4 + i%4) % 4) + i%4]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4*c+j] = n == 10 ? u[4*c+j] :
                     gmul(8'h02, u[4*c+j]) ^ gmul(8'h03, u[4*c+(j+1)%4]) ^ u[4*c+(j+2)%4] ^ u[4*c+(j+3)%4];
      rk = round_key(k, n);
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i] ^ rk[127-8*i -: 8];
    end
    return v;
  endfunction

  function automatic logic [127:0] aes_ct(input logic [127:0] pt, input logic [127:0] k);
    return state_in(pt, k, 11);
  endfunction

  function automatic logic [127:0] exp_sbox_in(input logic [127:0] pt, input logic [127:0] k, input int p);
    logic [127:0] rk;
    rk = round_key(k, p / 2);
    return p % 2 == 0 ? {rk[23:0], rk[31:24], 96'h0} : state_in(pt, k, (p + 1) / 2);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always_comb begin
    sbox_out = '0;
    for (int i = 0; i < 16; i++) sbox_out[127-8*i -: 8] = sbox_tab[sbox_in[127-8*i -: 8]];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_ct   <= '0;
      m_p    <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_p    <= 0;
        m_pt   <= plaintext;
        m_key  <= key;
      end
    end else if (m_p == 19) begin
      m_busy <= 1'b0;
      m_done <= 1'b1;
      m_ct   <= aes_ct(m_pt, m_key);
    end else begin
      m_p <= m_p + 1;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("ciphertext", ciphertext, m_ct);
      check("sbox_in", sbox_in, m_busy ? exp_sbox_in(m_pt, m_key, m_p) : 128'h0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [127:0] pt, input logic [127:0] k);
    plaintext = pt;
    key = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    vecs++;
    if (!done) begin
      errs++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    check("model_sbox_00", sbox_tab[8'h00], 8'h63);
    check("model_sbox_53", sbox_tab[8'h53], 8'hed);
    check("model_ct_B", aes_ct(PT_B, KEY_B), CT_B);
    check("model_ct_C", aes_ct(PT_C, KEY_C), CT_C);
    check("model_rk10_C", round_key(KEY_C, 10), RK10_C);
    tick(2);
    chk = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ct", ciphertext, 128'h0);
    check("rst_sbox_in", sbox_in, 128'h0);
    rst = 1'b0;
    tick();
    go(PT_B, KEY_B);
    wait_done(30, n);
    check("latency_B", n, 20);
    check("ct_B", ciphertext, CT_B);
    tick(3);
    go(PT_C, KEY_C);
    wait_done(30, n);
    check("ct_C", ciphertext, CT_C);
    check("rk10_C", dut.rk_q, RK10_C);
    tick(2);
    go(PT_B, KEY_B);
    tick(4);
    go(rnd128(), KEY_C);
    tick(9);
    go(rnd128(), rnd128());
    wait_done(30, n);
    check("ct_ignore_start", ciphertext, CT_B);
    tick(50);
    check("ct_hold", ciphertext, CT_B);
    plaintext = PT_B;
    key = KEY_B;
    start = 1'b1;
    tick();
    wait_done(30, n);
    for (int b = 0; b < 3; b++) begin
      tick();
      wait_done(30, n);
      check("hold_period", n + 1, 21);
      check("hold_ct", ciphertext, CT_B);
    end
    start = 1'b0;
    tick(2);
    go(PT_C, KEY_C);
    tick(8);
    rst = 1'b1;
    start = 1'b1;
    plaintext = PT_B;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ct", ciphertext, 128'h0);
    tick();
    go(PT_C, KEY_C);
    wait_done(30, n);
    check("ct_C_after_rst", ciphertext, CT_C);
    tick();
    for (int b = 0; b < 12; b++) begin
      go(rnd128(), rnd128());
      for (int i = 0; i < 24; i++) begin
        start = ($urandom % 4) == 0;
        plaintext = rnd128();
        key = rnd128();
        tick();
      end
      start = 1'b0;
      tick($urandom_range(0, 3));
    end
    tick(25);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
